// File: rtl/arrow_scroller.sv
// Beatmap-driven arrow spawner/scroller: walks the beatmap ROM, spawns arrows into two lanes,
// scrolls them once per frame and retires them on judge acknowledge (hit) or on reaching the top (miss).

module arrow_scroller_lane #(
    parameter logic [9:0] START_Y = 10'd480,
    parameter logic [9:0] MISS_Y  = 10'd16,
    parameter logic [3:0] SPEED   = 4'd2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       i_clr,
    input  logic       i_tick,
    input  logic       i_ack,
    input  logic       i_spawn,
    input  logic [3:0] i_spawn_id,
    output logic [3:0] o_id,
    output logic [9:0] o_posy,
    output logic       o_hit,
    output logic       o_miss
);
    logic [3:0] r_id;
    logic [9:0] r_posy;
    logic       w_occ;

    assign w_occ  = (r_id != 4'd0);
    // A judge ack on the same Clk as the miss condition takes priority.
    assign o_hit  = w_occ & i_ack & ~i_clr;
    assign o_miss = w_occ & ~i_ack & i_tick & (r_posy <= MISS_Y) & ~i_clr;
    assign o_id   = r_id;
    assign o_posy = r_posy;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_id   <= 4'd0;
            r_posy <= START_Y;
        end else if (i_clr || o_hit || o_miss) begin
            r_id   <= 4'd0;
            r_posy <= START_Y;
        end else if (w_occ && i_tick) begin
            r_posy <= r_posy - {6'd0, SPEED};
        end else if (!w_occ && i_spawn) begin
            r_id   <= i_spawn_id;
            r_posy <= START_Y;
        end
    end
endmodule

module arrow_scroller #(
    parameter logic [9:0] START_Y = 10'd480,
    parameter logic [9:0] MISS_Y  = 10'd16,
    parameter logic [3:0] SPEED   = 4'd2,
    parameter int         ADDR_W  = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              vs,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [3:0]        spriteID2,
    output logic [9:0]        posY2,
    output logic [3:0]        spriteID3,
    output logic [9:0]        posY3,
    input  logic              sprite2hit,
    input  logic              sprite3hit,
    output logic              miss_pulse,
    output logic [7:0]        miss_count,
    output logic [7:0]        hit_count,
    output logic              done
);
    localparam int NUM_LANES = 2;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_WAIT_GAP, S_SPAWN, S_DRAIN
    } state_t;

    state_t                       r_state;
    logic [ADDR_W-1:0]            r_addr;
    logic [1:0]                   r_dir;
    logic [4:0]                   r_gap;
    logic                         r_vs_s1, r_vs_s2, r_vs_s3;
    logic                         r_miss_pulse, r_done;
    logic [7:0]                   r_miss_cnt, r_hit_cnt;

    logic                         w_tick, w_start_ok, w_spawn_go, w_lane;
    logic [3:0]                   w_spawn_id;
    logic [NUM_LANES-1:0]         w_ack, w_spawn, w_hit, w_miss;
    logic [NUM_LANES-1:0][3:0]    w_id;
    logic [NUM_LANES-1:0][9:0]    w_posy;
    logic [1:0]                   w_hit_n, w_miss_n;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] n);
        logic [8:0] s;
        s = {1'b0, a} + {7'd0, n};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    assign w_tick     = r_vs_s2 & ~r_vs_s3;
    assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DRAIN);
    assign w_lane     = r_dir[1];
    assign w_spawn_go = (r_state == S_SPAWN) && (w_id[w_lane] == 4'd0);
    assign w_spawn    = {w_spawn_go & w_lane, w_spawn_go & ~w_lane};
    assign w_ack      = {sprite3hit, sprite2hit};
    assign w_hit_n    = {1'b0, w_hit[0]} + {1'b0, w_hit[1]};
    assign w_miss_n   = {1'b0, w_miss[0]} + {1'b0, w_miss[1]};

    always_comb begin
        w_spawn_id = 4'd0;
        case (r_dir)
            2'b00: w_spawn_id = 4'd4;
            2'b01: w_spawn_id = 4'd6;
            2'b10: w_spawn_id = 4'd5;
            2'b11: w_spawn_id = 4'd7;
            default: w_spawn_id = 4'd0;
        endcase
    end

    // Lane 0 is A (up/left), lane 1 is B (down/right).
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        arrow_scroller_lane #(
            .START_Y (START_Y),
            .MISS_Y  (MISS_Y),
            .SPEED   (SPEED)
        ) u_lane (
            .Clk        (Clk),
            .Reset_n    (Reset_n),
            .i_clr      (w_start_ok),
            .i_tick     (w_tick),
            .i_ack      (w_ack[g]),
            .i_spawn    (w_spawn[g]),
            .i_spawn_id (w_spawn_id),
            .o_id       (w_id[g]),
            .o_posy     (w_posy[g]),
            .o_hit      (w_hit[g]),
            .o_miss     (w_miss[g])
        );
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_dir        <= 2'd0;
            r_gap        <= 5'd0;
            r_vs_s1      <= 1'b0;
            r_vs_s2      <= 1'b0;
            r_vs_s3      <= 1'b0;
            r_miss_pulse <= 1'b0;
            r_done       <= 1'b0;
            r_miss_cnt   <= 8'd0;
            r_hit_cnt    <= 8'd0;
        end else begin
            r_vs_s1      <= vs;
            r_vs_s2      <= r_vs_s1;
            r_vs_s3      <= r_vs_s2;
            r_miss_pulse <= |w_miss;
            if (w_start_ok) begin
                r_miss_cnt <= 8'd0;
                r_hit_cnt  <= 8'd0;
            end else begin
                r_miss_cnt <= sat_add(r_miss_cnt, w_miss_n);
                r_hit_cnt  <= sat_add(r_hit_cnt, w_hit_n);
            end
            case (r_state)
                S_IDLE, S_DRAIN: begin
                    if (w_start_ok) begin
                        r_addr  <= '0;
                        r_done  <= 1'b0;
                        r_state <= S_FETCH;
                    end else if (r_state == S_DRAIN) begin
                        r_done  <= (w_id[0] == 4'd0) && (w_id[1] == 4'd0);
                    end
                end
                S_FETCH: r_state <= S_LOAD;
                S_LOAD: begin
                    r_dir   <= rom_data[6:5];
                    r_gap   <= rom_data[4:0];
                    r_state <= rom_data[7] ? S_WAIT_GAP : S_DRAIN;
                end
                S_WAIT_GAP: begin
                    if (r_gap == 5'd0)
                        r_state <= S_SPAWN;
                    else if (w_tick)
                        r_gap <= r_gap - 5'd1;
                end
                S_SPAWN: begin
                    // The address wraps naturally; the map terminates itself with valid=0.
                    if (w_spawn_go) begin
                        r_addr  <= r_addr + 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rom_addr   = r_addr;
    assign spriteID2  = w_id[0];
    assign posY2      = w_posy[0];
    assign spriteID3  = w_id[1];
    assign posY3      = w_posy[1];
    assign miss_pulse = r_miss_pulse;
    assign miss_count = r_miss_cnt;
    assign hit_count  = r_hit_cnt;
    assign done       = r_done;
endmodule

// File: doc/arrow_scroller.md
Name: arrow_scroller

Overview:
- Producer side of the judgement interface: walks a beatmap ROM and spawns arrow sprites in two lanes. It scrolls them upward once per video frame and publishes lane sprite ID and Y position to the judging logic.
- Lane A (sprite2) carries up/left arrows; lane B (sprite3) carries down/right arrows.
- Consumes the judging logic's per-lane "judged" acknowledgements, retires missed arrows, and reports hit/miss counts.
- Sits between the beatmap ROM and the judgement/sprite renderer.

Parameters:
- START_Y, 10'd480, Y at which a spawned arrow appears.
- MISS_Y, 10'd16, arrow retired as a miss when Y ≤ MISS_Y at a frame tick.
- SPEED, 4'd2, pixels subtracted from each active arrow per frame tick.
- ADDR_W, 8, beatmap ROM address width.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset_n  in  1  asynchronous active-low reset.
- vs  in  1  VGA vsync, asynchronous to block; rising edge = frame tick.
- start  in  1  one-cycle pulse; begins playback from address 0.
- rom_addr  out  ADDR_W  beatmap read address.
- rom_data  in  8  {valid[7], dir[6:5], gap[4:0]}; registered ROM, data valid 1 Clk after address.
- spriteID2  out  4  lane A sprite: 4=up, 6=left, 0=empty.
- posY2  out  10  lane A Y.
- spriteID3  out  4  lane B sprite: 5=down, 7=right, 0=empty.
- posY3  out  10  lane B Y.
- sprite2hit  in  1  judgement acknowledge for lane A (level, sampled each Clk).
- sprite3hit  in  1  judgement acknowledge for lane B.
- miss_pulse  out  1  one-Clk pulse per arrow retired unjudged.
- miss_count  out  8  saturating miss counter.
- hit_count  out  8  saturating judged counter.
- done  out  1  high once end-of-map reached and both lanes empty.

Behaviour:
- Reset (async, Reset_n=0): state IDLE; rom_addr=0; spriteID2=spriteID3=0; posY2=posY3=START_Y; counters 0; miss_pulse=0; done=0; vs synchronizer cleared.
- Frame tick: vs passes through a 2-flop synchronizer, then rising-edge detect. tick is a one-Clk pulse, 3 Clk after the vs edge.
- FSM states: IDLE, FETCH, LOAD, WAIT_GAP, SPAWN, DRAIN.
  - IDLE: start → FETCH; rom_addr=0; counters and done cleared.
  - FETCH: address stable for 1 Clk → LOAD.
  - LOAD: latch rom_data. valid=0 → DRAIN. Otherwise gap counter=gap → WAIT_GAP.
  - WAIT_GAP: decrement gap counter on each tick; when it is 0 → SPAWN. gap=0 spawns on the first Clk of WAIT_GAP.
  - SPAWN: target lane from dir:
    - dir 00 → A, ID 4.
    - dir 01 → A, ID 6.
    - dir 10 → B, ID 5.
    - dir 11 → B, ID 7.
  - SPAWN, lane empty (ID==0): set ID, posY=START_Y, rom_addr+1 → FETCH.
  - SPAWN, lane occupied: stall in SPAWN, no ROM advance, until the lane frees.
  - DRAIN: done=1 when both lanes empty. Stays in DRAIN until start.
- Scrolling, per lane, on tick with ID≠0:
  - posY ≤ MISS_Y: ID←0, posY←START_Y, miss_pulse=1 for 1 Clk, miss_count+1.
  - Otherwise posY←posY−SPEED.
  - The subtract never underflows because the miss check precedes it.
- Hit, per lane: ack high while ID≠0 → ID←0, posY←START_Y, hit_count+1, next Clk. Ack while lane empty is ignored. A held ack counts once, since the lane is empty afterward.
- Simultaneous events:
  - Hit and miss condition on the same Clk: hit wins, no miss_pulse.
  - Both lanes miss on the same tick: miss_count+2, miss_pulse still a single Clk.
  - Spawn and hit clearing the same lane: the spawn sees the lane occupied that Clk and succeeds the next Clk.
- Counters saturate at 8'hFF.
- Address wrap: rom_addr reaching 2^ADDR_W−1 with a valid entry wraps to 0; the map must terminate itself with valid=0.
- start outside IDLE/DRAIN is ignored. Reset mid-playback returns everything to reset values immediately.

Test Plan:
- Reset then start, ROM[0]=8'b1_00_00011, ROM[1]=0 → after 3 ticks spriteID2=4, posY2=480. Each subsequent tick posY2 drops by 2. done stays 0 until the lane retires.
- Same map, no ack → arrow reaches posY2≤16 → next tick spriteID2=0, miss_pulse one Clk, miss_count=1, done=1.
- Arrow at posY2=40, sprite2hit held 5 Clk → spriteID2=0 after 1 Clk, hit_count=1 (not 5), no miss_pulse.
- ROM: left gap0, up gap0 on the same lane → second spawn stalls (rom_addr holds 1) until the first arrow is hit or missed, then spriteID2=4.
- Lanes A and B both at posY=16 on one tick → both cleared, miss_count=2. Ack on lane B in the same Clk → miss_count=1, hit_count=1.
- Reset_n asserted mid-scroll, asynchronous to Clk → all outputs at reset values without a Clk edge. Restart replays from rom_addr=0.
